// File: rtl/alu_operand_fetch.sv
// Operand-fetch/issue stage: GPR file, decode, RAW scoreboard and a one-deep issue register to the ALU.
// Optional macro OPFETCH_BYPASS_EN lets a same-cycle writeback release a hazard and forward wb_data.
module alu_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_rega,
    output logic [DATA_W-1:0] out_regb,
    output logic [4:0]        out_dst,
    output logic              out_wen,
    input  logic              wb_valid,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_ovf,
    output logic              ovf_sticky
);

    localparam int AW = 5;

    // ---------------------------------------------------------------- decode
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] dec_dst;
    logic          dec_wen;
    logic          rs_used;
    logic          rt_used;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign rd    = in_instr[15:11];
    assign funct = in_instr[5:0];

    always_comb begin
        dec_dst = '0;
        dec_wen = 1'b0;
        rs_used = 1'b1;
        rt_used = 1'b0;
        case (op)
            6'h00: begin
                dec_dst = rd;
                dec_wen = 1'b1;
                rt_used = 1'b1;
                // Shift-by-immediate forms ignore rs
                if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) begin
                    rs_used = 1'b0;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23: begin
                dec_dst = rt;
                dec_wen = 1'b1;
            end
            6'h04, 6'h05, 6'h2B: begin
                rt_used = 1'b1;
            end
            default: begin
                dec_wen = 1'b0;
            end
        endcase
        if (dec_dst == '0) begin
            dec_wen = 1'b0;
        end
        if (rs == '0) begin
            rs_used = 1'b0;
        end
        if (rt == '0) begin
            rt_used = 1'b0;
        end
    end

    // ---------------------------------------------------------------- GPR file
    logic [DATA_W-1:0] gpr_val [NREG];
    logic              wb_write;

    assign wb_write = wb_valid && !wb_ovf;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                assign gpr_val[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] val_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        val_q <= '0;
                    end else if (wb_write && wb_dst == AW'(gi)) begin
                        val_q <= wb_data;
                    end
                end
                assign gpr_val[gi] = val_q;
            end
        end
    endgenerate

    // ---------------------------------------------------------------- hazard / operands
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic              clr_rs;
    logic              clr_rt;
    logic              wb_coll;
    logic              hz;
    logic              accept;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

`ifdef OPFETCH_BYPASS_EN
    assign clr_rs  = wb_valid && (wb_dst == rs);
    assign clr_rt  = wb_valid && (wb_dst == rt);
    assign wb_coll = 1'b0;
    // A trapped result is never forwarded; the old register value is used instead
    assign opa = (wb_write && wb_dst == rs && rs != '0) ? wb_data : gpr_val[rs];
    assign opb = (wb_write && wb_dst == rt && rt != '0) ? wb_data : gpr_val[rt];
`else
    assign clr_rs  = 1'b0;
    assign clr_rt  = 1'b0;
    // Without forwarding, a source written this cycle must be re-read after the write lands
    assign wb_coll = wb_write && (wb_dst != '0) &&
                     ((rs_used && wb_dst == rs) || (rt_used && wb_dst == rt));
    assign opa = gpr_val[rs];
    assign opb = gpr_val[rt];
`endif

    assign hz = (rs_used && pending_q[rs] && !clr_rs) ||
                (rt_used && pending_q[rt] && !clr_rt) ||
                wb_coll;

    logic out_valid_q;

    assign in_ready = (!out_valid_q || out_ready) && !hz;
    assign accept   = in_valid && in_ready;

    // Set after clear so a same-cycle issue to the written-back register stays pending
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_dst] = 1'b0;
        end
        if (accept && dec_wen) begin
            pending_d[dec_dst] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ---------------------------------------------------------------- issue register
    logic [31:0]       out_instr_q;
    logic [DATA_W-1:0] out_rega_q;
    logic [DATA_W-1:0] out_regb_q;
    logic [AW-1:0]     out_dst_q;
    logic              out_wen_q;
    logic              ovf_sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_rega_q  <= '0;
            out_regb_q  <= '0;
            out_dst_q   <= '0;
            out_wen_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_instr_q <= {in_instr[31:26], 5'd0, 5'd1, in_instr[15:0]};
            out_rega_q  <= opa;
            out_regb_q  <= opb;
            out_dst_q   <= dec_dst;
            out_wen_q   <= dec_wen;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (wb_valid && wb_ovf) begin
            ovf_sticky_q <= 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_rega   = out_rega_q;
    assign out_regb   = out_regb_q;
    assign out_dst    = out_dst_q;
    assign out_wen    = out_wen_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch; honours OPFETCH_BYPASS_EN for the same-cycle writeback case.
module tb_alu_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_rega;
    logic [31:0] out_regb;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_ovf;
    logic        ovf_sticky;

    int tests_run;
    int tests_failed;

    alu_operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_rega   (out_rega),
        .out_regb   (out_regb),
        .out_dst    (out_dst),
        .out_wen    (out_wen),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .wb_ovf     (wb_ovf),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wb(input logic [4:0] dst, input logic [31:0] data, input logic ovf);
        wb_valid = 1'b1;
        wb_dst   = dst;
        wb_data  = data;
        wb_ovf   = ovf;
        tick();
        wb_valid = 1'b0;
        wb_ovf   = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_dst    = '0;
        wb_data   = '0;
        wb_ovf    = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_rega", out_rega, 32'd0);
        check("rst_out_regb", out_regb, 32'd0);
        check("rst_out_dst", 32'(out_dst), 32'd0);
        check("rst_out_wen", 32'(out_wen), 32'd0);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: r1=5, r2=7, add r3,r1,r2
        wb(5'd1, 32'd5, 1'b0);
        wb(5'd2, 32'd7, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h00221820;
        #1;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_rega", out_rega, 32'd5);
        check("t1_regb", out_regb, 32'd7);
        check("t1_dst", 32'(out_dst), 32'd3);
        check("t1_wen", 32'(out_wen), 32'd1);
        check("t1_instr", out_instr, 32'h00011820);
        wb(5'd3, 32'd12, 1'b0);
        check("t1_drop", 32'(out_valid), 32'd0);

        // 2: addi r4,r3,1 then add r5,r4,r4 stalls until wb r4
        in_valid = 1'b1;
        in_instr = 32'h20640001;
        #1;
        check("t2_addi_ready", 32'(in_ready), 32'd1);
        tick();
        check("t2_addi_rega", out_rega, 32'd12);
        check("t2_addi_dst", 32'(out_dst), 32'd4);
        check("t2_addi_instr", out_instr, 32'h20010001);
        in_instr = 32'h00842820;
        #1;
        check("t2_stall0", 32'(in_ready), 32'd0);
        tick();
        check("t2_stall_valid", 32'(out_valid), 32'd0);
        check("t2_stall1", 32'(in_ready), 32'd0);
        wb_valid = 1'b1;
        wb_dst   = 5'd4;
        wb_data  = 32'd13;
        #1;
`ifdef OPFETCH_BYPASS_EN
        check("t2_wb_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
`else
        check("t2_wb_ready", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("t2_wb_noissue", 32'(out_valid), 32'd0);
        #1;
        check("t2_late_ready", 32'(in_ready), 32'd1);
        tick();
`endif
        in_valid = 1'b0;
        check("t2_add_valid", 32'(out_valid), 32'd1);
        check("t2_add_rega", out_rega, 32'd13);
        check("t2_add_regb", out_regb, 32'd13);
        check("t2_add_dst", 32'(out_dst), 32'd5);

        // 3: downstream backpressure for 3 cycles, then back-to-back issue
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h20290064;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_ready", 32'(in_ready), 32'd0);
            tick();
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_dst", 32'(out_dst), 32'd5);
            check("t3_hold_rega", out_rega, 32'd13);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("t3_b1_dst", 32'(out_dst), 32'd9);
        check("t3_b1_rega", out_rega, 32'd5);
        check("t3_b1_instr", out_instr, 32'h20010064);
        in_instr = 32'h204A0001;
        #1;
        check("t3_b2_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_b2_valid", 32'(out_valid), 32'd1);
        check("t3_b2_dst", 32'(out_dst), 32'd10);
        check("t3_b2_rega", out_rega, 32'd7);
        tick();
        check("t3_drain", 32'(out_valid), 32'd0);

        // 4: trapped overflow writeback to a pending r6
        in_valid = 1'b1;
        in_instr = 32'h20060000;
        tick();
        in_valid = 1'b0;
        wb(5'd6, 32'h7FFFFFFF, 1'b1);
        check("t4_sticky", 32'(ovf_sticky), 32'd1);
        in_valid = 1'b1;
        in_instr = 32'h00C65820;
        #1;
        check("t4_pending_clr", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t4_rega", out_rega, 32'd0);
        check("t4_regb", out_regb, 32'd0);
        check("t4_dst", 32'(out_dst), 32'd11);

        // 5: non-writing ops, r0 handling, shift ignoring pending rs
        in_valid = 1'b1;
        in_instr = 32'hAC220004;
        tick();
        check("t5_sw_wen", 32'(out_wen), 32'd0);
        check("t5_sw_rega", out_rega, 32'd5);
        check("t5_sw_regb", out_regb, 32'd7);
        in_instr = 32'h10220003;
        tick();
        check("t5_beq_wen", 32'(out_wen), 32'd0);
        in_instr = 32'h00220020;
        tick();
        check("t5_r0dst_wen", 32'(out_wen), 32'd0);
        in_valid = 1'b0;
        wb(5'd0, 32'hDEADBEEF, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h00006020;
        tick();
        check("t5_r0_rega", out_rega, 32'd0);
        check("t5_r0_regb", out_regb, 32'd0);
        check("t5_r0_wen", 32'(out_wen), 32'd1);
        in_instr = 32'h00A83880;
        #1;
        check("t5_sll_ready", 32'(in_ready), 32'd1);
        tick();
        check("t5_sll_dst", 32'(out_dst), 32'd7);
        check("t5_sll_instr", out_instr, 32'h00013880);

        // 6: asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_instr  = 32'h00A06820;
        #1;
        check("t6_stall", 32'(in_ready), 32'd0);
        tick();
        check("t6_held_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_instr", out_instr, 32'd0);
        check("t6_rega", out_rega, 32'd0);
        check("t6_dst", 32'(out_dst), 32'd0);
        check("t6_wen", 32'(out_wen), 32'd0);
        check("t6_sticky", 32'(ovf_sticky), 32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t6_pending_clr", 32'(in_ready), 32'd1);
        in_instr = 32'h00227020;
        tick();
        in_valid = 1'b0;
        check("t6_gpr_rega", out_rega, 32'd0);
        check("t6_gpr_regb", out_regb, 32'd0);
        check("t6_gpr_dst", 32'(out_dst), 32'd14);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
